// File: rtl/jump_sequencer.sv
// Instruction pointer owner: fetches over req/ack, issues over valid/ready, runs jump/wait/stop commands.
// Optional relative jump (port code 9) is compiled in when JUMP_SEQ_REL_JUMP_EN is defined.
module jump_sequencer #(
  parameter int                    DATA_WIDTH = 8,
  parameter logic [DATA_WIDTH-1:0] DEVICE_ID  = 'h01,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_wr_en,
  input  logic [DATA_WIDTH-1:0] i_device,
  input  logic [DATA_WIDTH-1:0] i_address,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_cmp_larger,
  input  logic                  i_cmp_smaller,
  input  logic                  i_cmp_equal,
  output logic                  o_fetch_req,
  output logic [DATA_WIDTH-1:0] o_fetch_addr,
  input  logic                  i_fetch_ack,
  input  logic [DATA_WIDTH-1:0] i_fetch_data,
  output logic                  o_ir_valid,
  output logic [DATA_WIDTH-1:0] o_ir,
  output logic [DATA_WIDTH-1:0] o_ir_pointer,
  input  logic                  i_ir_ready,
  output logic                  o_halted
);

  localparam logic [DATA_WIDTH-1:0] P_LARGER  = 'd1;
  localparam logic [DATA_WIDTH-1:0] P_SMALLER = 'd2;
  localparam logic [DATA_WIDTH-1:0] P_EQUAL   = 'd3;
  localparam logic [DATA_WIDTH-1:0] P_UNEQUAL = 'd4;
  localparam logic [DATA_WIDTH-1:0] P_DIRECT  = 'd5;
  localparam logic [DATA_WIDTH-1:0] P_ADDR    = 'd6;
  localparam logic [DATA_WIDTH-1:0] P_WAIT    = 'd7;
  localparam logic [DATA_WIDTH-1:0] P_STOP    = 'd8;
`ifdef JUMP_SEQ_REL_JUMP_EN
  localparam logic [DATA_WIDTH-1:0] P_REL     = 'd9;
`endif

  typedef enum logic [2:0] {ST_RST, ST_FETCH, ST_ISSUE, ST_WAIT, ST_HALT} state_t;

  state_t                state_reg;
  logic [DATA_WIDTH-1:0] pc_reg;
  logic [DATA_WIDTH-1:0] target_reg;
  logic [DATA_WIDTH-1:0] wait_cnt_reg;
  logic                  redirect_reg;
  logic                  fetch_req_reg;
  logic [DATA_WIDTH-1:0] fetch_addr_reg;
  logic                  ir_valid_reg;
  logic [DATA_WIDTH-1:0] ir_reg;
  logic [DATA_WIDTH-1:0] ir_pointer_reg;
  logic                  halted_reg;

  logic                  cmd_ok;
  logic                  cmd_addr;
  logic                  cmd_wait;
  logic                  cmd_stop;
  logic                  jump_taken;
  logic [DATA_WIDTH-1:0] jump_dest;
  logic [DATA_WIDTH-1:0] pc_next;

  always_comb begin
    cmd_ok     = i_wr_en && (i_device == DEVICE_ID) &&
                 (state_reg == ST_FETCH || state_reg == ST_ISSUE || state_reg == ST_WAIT);
    cmd_addr   = cmd_ok && (i_address == P_ADDR);
    cmd_wait   = cmd_ok && (i_address == P_WAIT);
    cmd_stop   = cmd_ok && (i_address == P_STOP);
    jump_taken = 1'b0;
    jump_dest  = target_reg;
    if (cmd_ok) begin
      case (i_address)
        P_LARGER:  jump_taken = i_cmp_larger;
        P_SMALLER: jump_taken = i_cmp_smaller;
        P_EQUAL:   jump_taken = i_cmp_equal;
        P_UNEQUAL: jump_taken = !i_cmp_equal;
        P_DIRECT:  jump_taken = 1'b1;
`ifdef JUMP_SEQ_REL_JUMP_EN
        P_REL: begin
          jump_taken = 1'b1;
          jump_dest  = ir_pointer_reg + i_data;
        end
`endif
        default:   jump_taken = 1'b0;
      endcase
    end
    // Address the next fetch will use, including a jump landing this cycle.
    pc_next = jump_taken ? jump_dest : pc_reg;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg      <= ST_RST;
      pc_reg         <= RESET_PC;
      target_reg     <= '0;
      wait_cnt_reg   <= '0;
      redirect_reg   <= 1'b0;
      fetch_req_reg  <= 1'b0;
      fetch_addr_reg <= '0;
      ir_valid_reg   <= 1'b0;
      ir_reg         <= '0;
      ir_pointer_reg <= '0;
      halted_reg     <= 1'b0;
    end else begin
      if (cmd_addr)
        target_reg <= i_data;
      if (jump_taken)
        pc_reg <= jump_dest;

      unique case (state_reg)
        ST_RST: begin
          state_reg      <= ST_FETCH;
          fetch_req_reg  <= 1'b1;
          fetch_addr_reg <= pc_reg;
        end

        ST_FETCH: begin
          if (cmd_wait)
            wait_cnt_reg <= i_data;
          if (cmd_stop) begin
            state_reg     <= ST_HALT;
            fetch_req_reg <= 1'b0;
            redirect_reg  <= 1'b0;
            halted_reg    <= 1'b1;
          end else if (i_fetch_ack) begin
            if (jump_taken || redirect_reg) begin
              // Word fetched from the stale address is dropped; re-request at the new pc.
              fetch_addr_reg <= pc_next;
              redirect_reg   <= 1'b0;
            end else begin
              ir_reg         <= i_fetch_data;
              ir_pointer_reg <= fetch_addr_reg;
              pc_reg         <= pc_reg + 1'b1;
              fetch_req_reg  <= 1'b0;
              ir_valid_reg   <= 1'b1;
              state_reg      <= ST_ISSUE;
            end
          end else if (jump_taken) begin
            redirect_reg <= 1'b1;
          end
        end

        ST_ISSUE: begin
          if (cmd_wait)
            wait_cnt_reg <= i_data;
          if (cmd_stop) begin
            state_reg    <= ST_HALT;
            ir_valid_reg <= 1'b0;
            halted_reg   <= 1'b1;
          end else if (i_ir_ready) begin
            ir_valid_reg <= 1'b0;
            if (cmd_wait && (i_data != '0)) begin
              state_reg <= ST_WAIT;
            end else begin
              state_reg      <= ST_FETCH;
              fetch_req_reg  <= 1'b1;
              fetch_addr_reg <= pc_next;
            end
          end
        end

        ST_WAIT: begin
          if (cmd_stop) begin
            state_reg  <= ST_HALT;
            halted_reg <= 1'b1;
          end else if (cmd_wait ? (i_data == '0) : (wait_cnt_reg <= 'd1)) begin
            // Leaving on the last idle cycle keeps exactly N idle cycles before the request.
            wait_cnt_reg   <= '0;
            state_reg      <= ST_FETCH;
            fetch_req_reg  <= 1'b1;
            fetch_addr_reg <= pc_next;
          end else begin
            wait_cnt_reg <= cmd_wait ? i_data : wait_cnt_reg - 1'b1;
          end
        end

        ST_HALT: begin
          state_reg <= ST_HALT;
        end

        default: state_reg <= ST_RST;
      endcase
    end
  end

  assign o_fetch_req  = fetch_req_reg;
  assign o_fetch_addr = fetch_addr_reg;
  assign o_ir_valid   = ir_valid_reg;
  assign o_ir         = ir_reg;
  assign o_ir_pointer = ir_pointer_reg;
  assign o_halted     = halted_reg;

endmodule

// File: tb/tb_jump_sequencer.sv
// Directed + randomized bench for jump_sequencer; expected fetch addresses come from a
// program-counter model driven by the commands the bench issues.
module tb_jump_sequencer;
  localparam logic [7:0] DEV = 8'h01;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       i_wr_en = 1'b0;
  logic [7:0] i_device = '0, i_address = '0, i_data = '0;
  logic       i_cmp_larger = 1'b0, i_cmp_smaller = 1'b0, i_cmp_equal = 1'b0;
  logic       o_fetch_req;
  logic [7:0] o_fetch_addr;
  logic       i_fetch_ack = 1'b0;
  logic [7:0] i_fetch_data = '0;
  logic       o_ir_valid;
  logic [7:0] o_ir, o_ir_pointer;
  logic       i_ir_ready = 1'b0;
  logic       o_halted;

  always #5 clk = ~clk;

  jump_sequencer #(.DATA_WIDTH(8), .DEVICE_ID(8'h01), .RESET_PC(8'h00)) dut (
    .clk(clk), .rst_n(rst_n), .i_wr_en(i_wr_en), .i_device(i_device),
    .i_address(i_address), .i_data(i_data), .i_cmp_larger(i_cmp_larger),
    .i_cmp_smaller(i_cmp_smaller), .i_cmp_equal(i_cmp_equal),
    .o_fetch_req(o_fetch_req), .o_fetch_addr(o_fetch_addr),
    .i_fetch_ack(i_fetch_ack), .i_fetch_data(i_fetch_data),
    .o_ir_valid(o_ir_valid), .o_ir(o_ir), .o_ir_pointer(o_ir_pointer),
    .i_ir_ready(i_ir_ready), .o_halted(o_halted)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: program memory, next fetch address, jump target, last issued address.
  logic [7:0] imem [256];
  logic [7:0] exp_pc = '0;
  logic [7:0] tgt = '0;
  logic [7:0] last_ptr = '0;
  int         exp_idle = 0;   // -1: idle gap not defined, skip that check

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic clear_in();
    i_wr_en = 1'b0; i_device = '0; i_address = '0; i_data = '0;
    i_cmp_larger = 1'b0; i_cmp_smaller = 1'b0; i_cmp_equal = 1'b0;
    i_fetch_ack = 1'b0; i_fetch_data = '0; i_ir_ready = 1'b0;
  endtask

  task automatic drive_cmd(input logic [7:0] dev, input logic [7:0] port, input logic [7:0] dat,
                           input logic [2:0] flg);
    i_wr_en = 1'b1; i_device = dev; i_address = port; i_data = dat;
    {i_cmp_larger, i_cmp_smaller, i_cmp_equal} = flg;
  endtask

  // Effect of an accepted command on the program counter, from the command semantics.
  task automatic model_cmd(input logic [7:0] dev, input logic [7:0] port, input logic [7:0] dat,
                           input logic [2:0] flg);
    if (dev != DEV) return;
    case (port)
      8'd1: if (flg[2]) exp_pc = tgt;
      8'd2: if (flg[1]) exp_pc = tgt;
      8'd3: if (flg[0]) exp_pc = tgt;
      8'd4: if (!flg[0]) exp_pc = tgt;
      8'd5: exp_pc = tgt;
      8'd6: tgt = dat;
      8'd7: exp_idle = int'(dat);
`ifdef JUMP_SEQ_REL_JUMP_EN
      8'd9: exp_pc = last_ptr + dat;
`endif
      default: ;
    endcase
  endtask

  task automatic wait_req(output int idle);
    idle = 0;
    while (o_fetch_req !== 1'b1 && idle < 64) begin
      tick();
      idle++;
    end
    check("fetch_req_seen", o_fetch_req, 1);
  endtask

  // One instruction fetch with `lat` extra request cycles before the ack.
  task automatic fetch(input int lat);
    int idle;
    wait_req(idle);
    if (exp_idle >= 0) check("idle_cycles", idle, exp_idle);
    exp_idle = 0;
    check("fetch_addr", o_fetch_addr, exp_pc);
    for (int i = 0; i < lat; i++) begin
      tick();
      check("req_hold", {o_fetch_req, o_fetch_addr}, {1'b1, exp_pc});
    end
    i_fetch_ack = 1'b1;
    i_fetch_data = imem[exp_pc];
    tick();
    i_fetch_ack = 1'b0;
    check("ir_valid", o_ir_valid, 1);
    check("ir_word", o_ir, imem[exp_pc]);
    check("ir_pointer", o_ir_pointer, exp_pc);
    $display("fetch addr=%02h lat=%0d ir=%02h ptr=%02h idle=%0d", exp_pc, lat, o_ir, o_ir_pointer, idle);
    last_ptr = exp_pc;
    exp_pc = exp_pc + 8'd1;
  endtask

  // Decoder accepts the word after `dly` stalled cycles, optionally with a command.
  task automatic issue(input int dly, input logic cmd, input logic [7:0] dev,
                       input logic [7:0] port, input logic [7:0] dat, input logic [2:0] flg);
    logic [7:0] held;
    held = o_ir;
    for (int i = 0; i < dly; i++) begin
      tick();
      check("ir_hold", {o_ir_valid, o_ir}, {1'b1, held});
    end
    i_ir_ready = 1'b1;
    if (cmd) drive_cmd(dev, port, dat, flg);
    tick();
    clear_in();
    if (cmd) model_cmd(dev, port, dat, flg);
  endtask

  // Jump on the command bus while a fetch is outstanding; the acked word must be dropped.
  task automatic fetch_redirect(input logic same_cycle);
    int idle;
    wait_req(idle);
    check("redir_addr0", o_fetch_addr, exp_pc);
    drive_cmd(DEV, 8'd5, 8'h00, 3'b000);
    if (same_cycle) begin
      i_fetch_ack = 1'b1;
      i_fetch_data = imem[exp_pc];
    end
    tick();
    clear_in();
    if (!same_cycle) begin
      check("redir_hold", {o_fetch_req, o_fetch_addr, o_ir_valid}, {1'b1, exp_pc, 1'b0});
      i_fetch_ack = 1'b1;
      i_fetch_data = imem[exp_pc];
      tick();
      clear_in();
    end
    check("redir_discard", o_ir_valid, 0);
    $display("redirect same_cycle=%0d from=%02h to=%02h", same_cycle, exp_pc, tgt);
    model_cmd(DEV, 8'd5, 8'h00, 3'b000);
    exp_idle = -1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_in();
    tick();
    check("reset_outputs", {o_fetch_req, o_fetch_addr, o_ir_valid, o_ir, o_ir_pointer, o_halted}, 0);
    tick();
    rst_n = 1'b1;
    tick();
    exp_pc = 8'h00; tgt = 8'h00; exp_idle = 0;
    $display("reset released");
  endtask

  initial begin
    logic [7:0] rp, rd, rdev;
    logic [2:0] rf;
    int         sel;
    int         idle;
    for (int i = 0; i < 256; i++) imem[i] = 8'($urandom);
    clear_in();

    // Sequential fetch after reset, 2-cycle memory, decoder always ready.
    do_reset();
    check("not_halted", o_halted, 0);
    for (int i = 0; i < 3; i++) begin
      fetch(2);
      issue(0, 1'b0, DEV, 0, 0, 0);
    end
    fetch(2); issue(0, 1'b1, DEV, 8'd6, 8'h40, 3'b000);       // ADDR 40 at 03
    fetch(2); issue(0, 1'b0, DEV, 0, 0, 0);                    // 04
    fetch(2); issue(1, 1'b1, DEV, 8'd5, 8'h00, 3'b000);       // DIRECT at 05
    fetch(0); issue(0, 1'b1, DEV, 8'd6, 8'h20, 3'b000);       // at 40: ADDR 20
    fetch(1); issue(0, 1'b1, DEV, 8'd3, 8'h00, 3'b100);       // EQUAL, equal=0: not taken
    fetch(1); issue(0, 1'b1, DEV, 8'd4, 8'h00, 3'b100);       // UNEQUAL: taken
    fetch(0); issue(0, 1'b1, DEV, 8'd7, 8'd3, 3'b000);        // at 20: WAIT 3
    fetch(0); issue(0, 1'b1, DEV, 8'd7, 8'd0, 3'b000);        // WAIT 0
    fetch(0); issue(0, 1'b1, DEV, 8'd6, 8'h50, 3'b000);
    fetch(1); issue(0, 1'b1, DEV, 8'd7, 8'd3, 3'b000);
    // Jump during the wait: pc moves, the wait keeps counting (one idle cycle already spent here).
    check("wait_idle", o_fetch_req, 0);
    drive_cmd(DEV, 8'd5, 8'h00, 3'b000);
    tick();
    clear_in();
    model_cmd(DEV, 8'd5, 8'h00, 3'b000);
    exp_idle = 2;
    fetch(1); issue(0, 1'b1, DEV, 8'd6, 8'h10, 3'b000);       // at 50
    fetch_redirect(1'b0);
    fetch(1); issue(0, 1'b1, DEV, 8'd6, 8'h70, 3'b000);       // at 10
    fetch_redirect(1'b1);
    fetch(0); issue(0, 1'b1, DEV, 8'd6, 8'hFF, 3'b000);       // at 70
    fetch(0); issue(0, 1'b1, DEV, 8'd5, 8'h00, 3'b000);
    fetch(1); issue(0, 1'b0, DEV, 0, 0, 0);                    // FF
    fetch(1); issue(0, 1'b1, DEV, 8'd6, 8'h30, 3'b000);       // wraps to 00
    fetch(0); issue(0, 1'b1, DEV, 8'd5, 8'h00, 3'b000);
    fetch(0); issue(0, 1'b1, DEV, 8'd9, 8'hFE, 3'b000);       // at 30: REL -2 (or ignored)
    fetch(0); issue(0, 1'b0, DEV, 0, 0, 0);

    // Randomized instruction stream.
    for (int n = 0; n < 150; n++) begin
      fetch($urandom_range(0, 3));
      sel = $urandom_range(0, 9);
      rf  = 3'($urandom);
      rd  = 8'($urandom);
      case (sel)
        3, 8: issue($urandom_range(0, 2), 1'b1, DEV, 8'd6, rd, rf);
        4, 9: issue($urandom_range(0, 2), 1'b1, DEV, 8'($urandom_range(1, 5)), rd, rf);
        5:    issue($urandom_range(0, 2), 1'b1, DEV, 8'd7, 8'($urandom_range(0, 4)), rf);
        6: begin
          rp = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(9, 255));
          issue($urandom_range(0, 2), 1'b1, DEV, rp, rd, rf);
        end
        7: begin
          rdev = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(2, 255));
          issue($urandom_range(0, 2), 1'b1, rdev, 8'($urandom_range(1, 9)), rd, rf);
        end
        default: issue($urandom_range(0, 2), 1'b0, DEV, 0, 0, 0);
      endcase
    end

    // STOP while a fetch is outstanding: halt, ignore the late ack and further commands.
    wait_req(idle);
    drive_cmd(DEV, 8'd8, 8'h00, 3'b000);
    tick();
    clear_in();
    check("halt_enter", {o_halted, o_fetch_req, o_ir_valid}, 3'b100);
    i_fetch_ack = 1'b1;
    i_fetch_data = 8'hA5;
    tick();
    clear_in();
    for (int i = 0; i < 4; i++) begin
      drive_cmd(DEV, 8'd5, 8'h00, 3'b000);
      tick();
      clear_in();
      check("halt_stay", {o_halted, o_fetch_req, o_ir_valid}, 3'b100);
    end
    $display("halted after stop");

    // Reset out of HALT, then reset while an instruction is being issued.
    do_reset();
    fetch(1);
    do_reset();
    fetch(2); issue(0, 1'b0, DEV, 0, 0, 0);
    fetch(0); issue(0, 1'b0, DEV, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
